// File: rtl/pulse_avg_ctrl.sv
// pulse_avg_ctrl: coherent pulse averager.
// Accumulates 2^cfg_log2_num pulses of (cfg_len+1) signed samples into an
// external read-modify-write memory, then reads the sums back, scales them
// by an arithmetic right shift and streams them out through a 4-deep FIFO.
// Optional feature macro: PULSE_AVG_ROUND_EN (round half up before the shift;
// when undefined the shift truncates toward minus infinity).
module pulse_avg_ctrl #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32,
    parameter int IWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [AWIDTH-1:0]        cfg_len,
    input  logic [3:0]               cfg_log2_num,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    input  logic [IWIDTH-1:0]        in_tdata,
    input  logic                     in_tvalid,
    output logic                     in_tready,
    input  logic                     in_tlast,
    output logic [DWIDTH-1:0]        out_tdata,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    output logic                     out_tlast,
    output logic [AWIDTH-1:0]        mem_rd_addr,
    output logic                     mem_rd_ena,
    input  logic [DWIDTH-1:0]        mem_rd_data,
    output logic [AWIDTH-1:0]        mem_wr_addr,
    output logic [DWIDTH-1:0]        mem_wr_data,
    output logic                     mem_wr_ena
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DUMP} state_t;

    state_t state_q, state_d;

    logic [AWIDTH-1:0] len_q, len_d;
    logic [3:0]        log2_q, log2_d;
    logic [AWIDTH-1:0] idx_q, idx_d;
    logic [15:0]       pulse_q, pulse_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              drain_q, drain_d;

    logic              v1_q, v1_d, v2_q, v2_d;
    logic [IWIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [AWIDTH-1:0] a1_q, a1_d, a2_q, a2_d;

    logic [AWIDTH-1:0] rd_idx_q, rd_idx_d;
    logic              rd_done_q, rd_done_d;
    logic              rv1_q, rv1_d, rv2_q, rv2_d;
    logic              rl1_q, rl1_d, rl2_q, rl2_d;

    logic [DWIDTH-1:0] fifo_data_q [4];
    logic [DWIDTH-1:0] fifo_data_d [4];
    logic              fifo_last_q [4];
    logic              fifo_last_d [4];
    logic [1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2:0]        cnt_q, cnt_d;

    logic              in_beat;
    logic              idx_last;
    logic              pulse_last;
    logic [15:0]       pulse_max;
    logic              room;
    logic              rd_issue;
    logic              out_hs;
    logic              last_hs;
    logic [DWIDTH-1:0] round_add;
    logic signed [DWIDTH-1:0] rd_sum;
    logic signed [DWIDTH-1:0] scaled;
    logic [DWIDTH-1:0] sext_s2;

    assign in_beat    = (state_q == ACCUM) && in_tvalid;
    assign idx_last   = (idx_q == len_q);
    assign pulse_max  = (16'd1 << log2_q) - 16'd1;
    assign pulse_last = (pulse_q == pulse_max);
    assign room       = ({1'b0, cnt_q} + {3'b000, rv1_q} + {3'b000, rv2_q}) < 4'd4;
    assign rd_issue   = (state_q == DUMP) && !rd_done_q && room;
    assign out_hs     = (cnt_q != 3'd0) && out_tready;
    assign last_hs    = out_hs && fifo_last_q[rptr_q];
    assign sext_s2    = {{(DWIDTH-IWIDTH){s2_q[IWIDTH-1]}}, s2_q};

`ifdef PULSE_AVG_ROUND_EN
    assign round_add = (log2_q == 4'd0) ? '0 : (DWIDTH'(1) << (log2_q - 4'd1));
`else
    assign round_add = '0;
`endif
    assign rd_sum = $signed(mem_rd_data + round_add);
    assign scaled = rd_sum >>> log2_q;

    // State and datapath registers, all cleared by the synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            log2_q    <= '0;
            idx_q     <= '0;
            pulse_q   <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            drain_q   <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            a1_q      <= '0;
            a2_q      <= '0;
            rd_idx_q  <= '0;
            rd_done_q <= 1'b0;
            rv1_q     <= 1'b0;
            rv2_q     <= 1'b0;
            rl1_q     <= 1'b0;
            rl2_q     <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            log2_q    <= log2_d;
            idx_q     <= idx_d;
            pulse_q   <= pulse_d;
            err_q     <= err_d;
            done_q    <= done_d;
            drain_q   <= drain_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            a1_q      <= a1_d;
            a2_q      <= a2_d;
            rd_idx_q  <= rd_idx_d;
            rd_done_q <= rd_done_d;
            rv1_q     <= rv1_d;
            rv2_q     <= rv2_d;
            rl1_q     <= rl1_d;
            rl2_q     <= rl2_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            for (int i = 0; i < 4; i++) begin
                fifo_data_q[i] <= fifo_data_d[i];
                fifo_last_q[i] <= fifo_last_d[i];
            end
        end
    end

    // Next-state logic: run accumulation, wait out the write pipeline, dump, back to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (in_beat && idx_last && pulse_last) state_d = DRAIN;
            DRAIN:   if (drain_q) state_d = DUMP;
            DUMP:    if (last_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters, accumulate pipeline, dump read pipeline and output FIFO
    always_comb begin
        len_d       = len_q;
        log2_d      = log2_q;
        idx_d       = idx_q;
        pulse_d     = pulse_q;
        err_d       = err_q;
        rd_idx_d    = rd_idx_q;
        rd_done_d   = rd_done_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;

        if ((state_q == IDLE) && start) begin
            len_d     = cfg_len;
            log2_d    = cfg_log2_num;
            err_d     = 1'b0;
            idx_d     = '0;
            pulse_d   = '0;
            rd_idx_d  = '0;
            rd_done_d = 1'b0;
        end

        if (in_beat) begin
            if (in_tlast != idx_last) err_d = 1'b1;
            if (idx_last) begin
                idx_d = '0;
                if (!pulse_last) pulse_d = pulse_q + 16'd1;
            end else begin
                idx_d = idx_q + AWIDTH'(1);
            end
        end

        drain_d = (state_q == DRAIN) && !drain_q;
        done_d  = last_hs;

        v1_d = in_beat;
        s1_d = in_tdata;
        a1_d = idx_q;
        v2_d = v1_q;
        s2_d = s1_q;
        a2_d = a1_q;

        rv1_d = rd_issue;
        rl1_d = rd_issue && (rd_idx_q == len_q);
        rv2_d = rv1_q;
        rl2_d = rl1_q;
        if (rd_issue) begin
            if (rd_idx_q == len_q) rd_done_d = 1'b1;
            else                   rd_idx_d  = rd_idx_q + AWIDTH'(1);
        end

        if (rv2_q) begin
            fifo_data_d[wptr_q] = scaled;
            fifo_last_d[wptr_q] = rl2_q;
            wptr_d              = wptr_q + 2'd1;
        end
        if (out_hs) rptr_d = rptr_q + 2'd1;
        cnt_d = cnt_q + {2'b00, rv2_q} - {2'b00, out_hs};
    end

    // Output decode from state and registered pipeline/FIFO contents
    always_comb begin
        busy        = (state_q != IDLE);
        done        = done_q;
        err         = err_q;
        in_tready   = (state_q == ACCUM);
        out_tvalid  = (cnt_q != 3'd0);
        out_tdata   = out_tvalid ? fifo_data_q[rptr_q] : '0;
        out_tlast   = out_tvalid ? fifo_last_q[rptr_q] : 1'b0;
        mem_rd_addr = '0;
        mem_rd_ena  = 1'b0;
        if (state_q == ACCUM) begin
            mem_rd_addr = idx_q;
            mem_rd_ena  = in_tvalid && (pulse_q != 16'd0);
        end else if (state_q == DUMP) begin
            mem_rd_addr = rd_idx_q;
            mem_rd_ena  = rd_issue;
        end
        mem_wr_ena  = v2_q;
        mem_wr_addr = a2_q;
        mem_wr_data = v2_q ? (sext_s2 + mem_rd_data) : '0;
    end

endmodule

// File: tb/tb_pulse_avg_ctrl.sv
// Testbench for pulse_avg_ctrl: external memory model, directed runs,
// behavioural averaging model with per-beat output comparison and literal pins.
module tb_pulse_avg_ctrl;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int IW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   cfg_len = '0;
    logic [3:0]      cfg_log2_num = '0;
    logic            busy, done, err;
    logic [IW-1:0]   in_tdata = '0;
    logic            in_tvalid = 1'b0;
    logic            in_tready;
    logic            in_tlast = 1'b0;
    logic [DW-1:0]   out_tdata;
    logic            out_tvalid;
    logic            out_tready = 1'b1;
    logic            out_tlast;
    logic [AW-1:0]   mem_rd_addr;
    logic            mem_rd_ena;
    logic [DW-1:0]   mem_rd_data;
    logic [AW-1:0]   mem_wr_addr;
    logic [DW-1:0]   mem_wr_data;
    logic            mem_wr_ena;

    pulse_avg_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .IWIDTH(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_log2_num(cfg_log2_num),
        .busy(busy), .done(done), .err(err),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
        .mem_rd_addr(mem_rd_addr), .mem_rd_ena(mem_rd_ena), .mem_rd_data(mem_rd_data),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_ena(mem_wr_ena)
    );

    always #5 clk = ~clk;

    // External memory: two-cycle read latency, zero data when read not enabled
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdPipe = '0;
    initial mem_rd_data = '0;
    initial for (int i = 0; i < (1<<AW); i++) mem[i] = $urandom;
    always @(posedge clk) begin
        if (mem_wr_ena) mem[mem_wr_addr] <= mem_wr_data;
        rdPipe      <= mem_rd_ena ? mem[mem_rd_addr] : '0;
        mem_rd_data <= rdPipe;
    end

    int     checkCount = 0;
    int     failCount = 0;
    longint expQ[$];
    bit     expLast[$];
    longint gotQ[$];
    int     litQ[$];
    int     stimData[$];
    bit     stimLast[$];
    int     gapMax = 0;
    int     readyMode = 0;
    int     dumpReads = 0;
    int     beatsOut = 0;
    bit     expectDone = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, $signed(got), $signed(exp));
        end
    endtask

    task automatic finishSim();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    endtask

    task automatic abortRun(input string name);
        checkCount++;
        failCount++;
        $display("[TB] FAIL %s: timeout, expected event never occurred", name);
        finishSim();
    endtask

    // Averaging model: per-index sum across pulses, optional round, floor divide
    function automatic void buildModel(input int len, input int log2n);
        int n = len + 1;
        int np = 1 << log2n;
        for (int j = 0; j < n; j++) begin
            longint s = 0;
            longint d = longint'(np);
            longint q;
            for (int p = 0; p < np; p++) s += longint'(stimData[p*n + j]);
`ifdef PULSE_AVG_ROUND_EN
            if (log2n > 0) s += longint'(1) << (log2n - 1);
`endif
            q = s / d;
            if ((s % d) != 0 && s < 0) q = q - 1;
            expQ.push_back(q);
            expLast.push_back(j == len);
        end
    endfunction

    // Start a run and push nBeats samples from the stimulus queues with random gaps
    task automatic applyStimulus(input int len, input int log2n, input int nBeats);
        gotQ.delete();
        dumpReads = 0;
        beatsOut  = 0;
        @(posedge clk); #1;
        cfg_len      = AW'(len);
        cfg_log2_num = 4'(log2n);
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        cfg_len      = '0;
        cfg_log2_num = '0;
        check("err_cleared_on_start", err, 1'b0);
        check("busy_after_start", busy, 1'b1);
        for (int b = 0; b < nBeats; b++) begin
            int gap = (gapMax > 0) ? $urandom_range(0, gapMax) : 0;
            int guard = 0;
            bit hs = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            in_tvalid = 1'b1;
            in_tdata  = IW'(stimData[b]);
            in_tlast  = stimLast[b];
            while (!hs) begin
                @(negedge clk);
                hs = in_tready;
                @(posedge clk); #1;
                guard++;
                if (!hs && guard > 200) abortRun("in_tready_wait");
            end
            in_tvalid = 1'b0;
            in_tlast  = 1'b0;
        end
    endtask

    task automatic waitDone(input int budget);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < budget);
        if (!done) abortRun("done_wait");
        @(posedge clk); #1;
    endtask

    // Compare captured DUT outputs and err against hand-computed literals
    task automatic checkOutput(input string name, input bit expErr);
        check({name, "_beat_count"}, gotQ.size(), litQ.size());
        for (int i = 0; i < litQ.size(); i++) begin
            if (i < gotQ.size()) check({name, "_lit"}, gotQ[i], longint'(litQ[i]));
        end
        check({name, "_model_drained"}, expQ.size(), 0);
        check({name, "_err"}, err, expErr);
        check({name, "_busy_idle"}, busy, 1'b0);
    endtask

    task automatic checkReset(input string name);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_done"}, done, 1'b0);
        check({name, "_err"}, err, 1'b0);
        check({name, "_in_tready"}, in_tready, 1'b0);
        check({name, "_out_tvalid"}, out_tvalid, 1'b0);
        check({name, "_out_tlast"}, out_tlast, 1'b0);
        check({name, "_out_tdata"}, out_tdata, 0);
        check({name, "_mem_rd_ena"}, mem_rd_ena, 1'b0);
        check({name, "_mem_wr_ena"}, mem_wr_ena, 1'b0);
        check({name, "_mem_rd_addr"}, mem_rd_addr, 0);
        check({name, "_mem_wr_addr"}, mem_wr_addr, 0);
        check({name, "_mem_wr_data"}, mem_wr_data, 0);
    endtask

    // Random output backpressure when enabled
    initial forever begin
        @(posedge clk); #1;
        if (readyMode == 1) out_tready = 1'($urandom_range(0, 1));
    end

    // Per-cycle compare against the model: output beats, done timing, outstanding reads
    initial begin : compareProc
        longint e;
        bit l;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("done_timing", done, expectDone);
                if (expectDone) check("busy_low_with_done", busy, 1'b0);
                expectDone = 1'b0;
                if (mem_rd_ena && !in_tready && busy) begin
                    dumpReads++;
                    check("reads_outstanding_le4", (dumpReads - beatsOut) <= 4, 1'b1);
                end
                if (out_tvalid && out_tready) begin
                    beatsOut++;
                    gotQ.push_back(longint'($signed(out_tdata)));
                    if (expQ.size() == 0) begin
                        checkCount++;
                        failCount++;
                        $display("[TB] FAIL unexpected_beat: got data %0d, expected no beat", $signed(out_tdata));
                    end else begin
                        e = expQ.pop_front();
                        l = expLast.pop_front();
                        check("out_tdata", $signed(out_tdata), e);
                        check("out_tlast", out_tlast, l);
                        expectDone = l;
                    end
                end
            end else begin
                expectDone = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        abortRun("global_watchdog");
    end

    initial begin
        $display("[TB] reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkReset("init_reset");
        @(posedge clk); #1;
        rst = 1'b1;

        $display("[TB] four pulses of 100, len 8, no stalls");
        stimData.delete(); stimLast.delete();
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 8; j++) begin
                stimData.push_back(100);
                stimLast.push_back(j == 7);
            end
        gapMax = 0;
        applyStimulus(7, 2, 32);
        buildModel(7, 2);
        waitDone(200);
        litQ = '{100, 100, 100, 100, 100, 100, 100, 100};
        checkOutput("const100", 1'b0);

        $display("[TB] two pulses with input gaps and random backpressure");
        stimData = '{1, 2, 3, 4, 2, 2, 2, 2};
        stimLast = '{0, 0, 0, 1, 0, 0, 0, 1};
        gapMax = 2;
        readyMode = 1;
        applyStimulus(3, 1, 8);
        buildModel(3, 1);
        waitDone(300);
        readyMode = 0;
        out_tready = 1'b1;
`ifdef PULSE_AVG_ROUND_EN
        litQ = '{2, 2, 3, 3};
`else
        litQ = '{1, 2, 2, 3};
`endif
        checkOutput("two_pulse", 1'b0);

        $display("[TB] early tlast sets sticky err");
        stimData = '{10, 20, 30, 40};
        stimLast = '{0, 0, 1, 0};
        gapMax = 0;
        applyStimulus(3, 0, 4);
        buildModel(3, 0);
        waitDone(200);
        repeat (3) @(posedge clk);
        #1;
        litQ = '{10, 20, 30, 40};
        checkOutput("tlast_err", 1'b1);

        $display("[TB] single pulse signed pass-through");
        stimData = '{-5, -6, 7, 0};
        stimLast = '{0, 0, 0, 1};
        applyStimulus(3, 0, 4);
        buildModel(3, 0);
        waitDone(200);
        litQ = '{-5, -6, 7, 0};
        checkOutput("signed_pass", 1'b0);

        $display("[TB] output stall during dump");
        stimData = '{1, 2, 3, 4, 5, 6, 7, 8};
        stimLast = '{0, 0, 0, 0, 0, 0, 0, 1};
        out_tready = 1'b0;
        applyStimulus(7, 0, 8);
        buildModel(7, 0);
        begin
            int c = 0;
            do begin @(negedge clk); c++; end while (!out_tvalid && c < 50);
            if (!out_tvalid) abortRun("stall_first_beat");
        end
        repeat (20) @(negedge clk);
        @(posedge clk); #2;
        check("stall_outstanding_reads", dumpReads - beatsOut, 4);
        check("stall_beats_out", beatsOut, 0);
        check("stall_out_tvalid", out_tvalid, 1'b1);
        out_tready = 1'b1;
        waitDone(200);
        litQ = '{1, 2, 3, 4, 5, 6, 7, 8};
        checkOutput("stall", 1'b0);

        $display("[TB] reset mid-accumulation then clean run");
        stimData = '{50, 60, 70, 80, 51, 61, 71, 81};
        stimLast = '{0, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(3, 1, 6);
        check("pre_reset_err", err, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkReset("mid_reset");
        rst = 1'b1;
        stimData = '{4, 8, 12, 16, 6, 10, 14, 18};
        stimLast = '{0, 0, 0, 1, 0, 0, 0, 1};
        applyStimulus(3, 1, 8);
        buildModel(3, 1);
        waitDone(200);
        litQ = '{5, 9, 13, 17};
        checkOutput("after_reset", 1'b0);

        repeat (2) @(posedge clk);
        finishSim();
    end

endmodule

// File: doc/pulse_avg_ctrl.md
PULSE_AVG_CTRL -- requirements
Module: pulse_avg_ctrl

Interface
REQ-001 Parameter AWIDTH, default 12: memory address width; pulse length up to 2^AWIDTH samples.
REQ-002 Parameter DWIDTH, default 32: accumulator and memory data width.
REQ-003 Parameter IWIDTH, default 16: signed input sample width; DWIDTH SHALL be >= IWIDTH+15.
REQ-004 Ports: one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous reset, active-low (0 = reset).
REQ-007 start  in  1  begin an averaging run; latches cfg_len and cfg_log2_num.
REQ-008 cfg_len  in  AWIDTH  samples per pulse minus 1; legal range 3..2^AWIDTH-1.
REQ-009 cfg_log2_num  in  4  log2 of pulses to average (1..32768 pulses).
REQ-010 busy  out  1  high from the cycle after an accepted start until done.
REQ-011 done  out  1  one-cycle pulse after the last output beat is accepted.
REQ-012 err  out  1  sticky: in_tlast disagreed with the sample count; cleared by the next accepted start.
REQ-013 in_tdata/in_tvalid/in_tready/in_tlast  in/in/out/in  IWIDTH/1/1/1  signed sample stream.
REQ-014 out_tdata/out_tvalid/out_tready/out_tlast  out/out/in/out  DWIDTH/1/1/1  averaged pulse stream.
REQ-015 mem_rd_addr/mem_rd_ena/mem_rd_data  out/out/in  AWIDTH/1/DWIDTH  memory read port; data returns 2 cycles after address and is 0 if rd_ena was low.
REQ-016 mem_wr_addr/mem_wr_data/mem_wr_ena  out/out/out  AWIDTH/DWIDTH/1  memory write port; write takes effect at the clock edge.

Function
REQ-017 The FSM SHALL have states IDLE, ACCUM, DRAIN and DUMP.
REQ-018 IDLE: in_tready=0; start=1 latches config, clears err and sample/pulse counters, and moves to ACCUM; start in any other state is ignored.
REQ-019 ACCUM: in_tready=1; each in_tvalid beat at index i issues mem_rd_addr=i, with mem_rd_ena=0 for pulse 0 and 1 otherwise.
REQ-020 The sample SHALL be sign-extended to DWIDTH and delayed 2 cycles, added modulo 2^DWIDTH to mem_rd_data, and written to address i with mem_wr_ena=1 exactly 2 cycles after acceptance.
REQ-021 The sample index SHALL wrap from cfg_len to 0 and increment the pulse count; after pulse 2^cfg_log2_num-1 completes, the FSM SHALL move to DRAIN.
REQ-022 Input stalls (in_tvalid=0) insert bubbles with mem_wr_ena=0; the pipeline never drops or repeats a beat.
REQ-023 A beat whose in_tlast differs from (index==cfg_len) SHALL set err; counting still follows cfg_len.
REQ-024 DRAIN: wait 2 cycles for the final writes, then go to DUMP; in_tready=0.
REQ-025 DUMP: read addresses 0..cfg_len in order with mem_rd_ena=1, shift each returned sum arithmetically right by cfg_log2_num, and push the result into a 4-entry output FIFO.
REQ-026 A read SHALL be issued only when FIFO occupancy plus reads in flight is < 4; the FIFO never overflows and out_tready may stall indefinitely.
REQ-027 out_tlast SHALL be asserted on the beat for address cfg_len; its handshake asserts done the next cycle and returns the FSM to IDLE with busy=0.
REQ-028 A simultaneous in-flight write and output read of the same address cannot occur because cfg_len >= 3; cfg_len < 3 is illegal and its behaviour is unspecified.

Reset
REQ-029 rst=0 at any clock edge, including mid-ACCUM or mid-DUMP, SHALL force IDLE, flush the FIFO and pipeline, and zero all counters.
REQ-030 Outputs held during reset: busy=0, done=0, err=0, in_tready=0, out_tvalid=0, out_tlast=0, out_tdata=0, mem_rd_ena=0, mem_wr_ena=0, addresses=0, mem_wr_data=0.
REQ-031 Memory contents SHALL NOT be cleared; correctness relies on mem_rd_ena=0 during pulse 0.

Configuration
REQ-032 Macro PULSE_AVG_ROUND_EN: when defined, 2^(cfg_log2_num-1) is added before the shift (round half up; no add when cfg_log2_num=0); when undefined, the shift truncates toward minus infinity.

Verification
REQ-033 cfg_len=7, cfg_log2_num=2, four pulses of constant 100, no stalls -> 8 outputs of 100, out_tlast on the 8th beat, done one cycle later, err=0.
REQ-034 cfg_len=3, cfg_log2_num=1, pulses {1,2,3,4} and {2,2,2,2}, random in_tvalid gaps -> outputs 1,2,2,3 truncated; with PULSE_AVG_ROUND_EN: 2,2,3,3.
REQ-035 cfg_log2_num=0, samples -5,-6,7,0 with cfg_len=3 -> outputs -5,-6,7,0 (single-pulse pass-through, signed).
REQ-036 DUMP with out_tready held low for 20 cycles -> exactly 4 beats buffered, no more than 4 outstanding reads, none lost after release.
REQ-037 in_tlast asserted at index 2 with cfg_len=3 -> err=1 until the next start, and output data are unaffected.
REQ-038 rst=0 for 1 cycle mid-ACCUM, then start a new run -> reset values hold and the new run's output equals a clean run (stale memory ignored).
